// File: rtl/ppu_defines.sv
// Shared types and constants for the VGA scanline buffer controller.
package ppu_defines;

   localparam int         LB_LINE_W       = 256;
   localparam logic [5:0] LB_UNDERRUN_PIX = 6'h0F;

   typedef enum logic {WR_FILL, WR_STALL} vga_lb_wr_state_t;
   typedef enum logic {RD_IDLE, RD_SHOW}  vga_lb_rd_state_t;

endpackage

// File: rtl/vga_linebuf_bank.sv
// One scanline bank: LINE_W x PIX_W register array, sync write, async read.
module vga_linebuf_bank
   import ppu_defines::*;
#(
   parameter int LINE_W = LB_LINE_W,
   parameter int IDX_W  = 8,
   parameter int PIX_W  = 6
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [PIX_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem_q [LINE_W];

   // Contents are deliberately not reset; the controller's full flags gate visibility.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/vga_linebuf_ctrl.sv
// Ping-pong scanline buffer controller between the PPU writer and VGA scan-out.
// Define VGA_LINEBUF_STATS_EN to add saturating overrun/underrun counters.
module vga_linebuf_ctrl
   import ppu_defines::*;
#(
   parameter int               LINE_W       = LB_LINE_W,
   parameter int               IDX_W        = 8,
   parameter int               PIX_W        = 6,
   parameter int               REPEAT       = 2,
   parameter logic [PIX_W-1:0] UNDERRUN_PIX = LB_UNDERRUN_PIX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             ppu_pix_we,
   input  logic [IDX_W-1:0] ppu_pix_x,
   input  logic [PIX_W-1:0] ppu_pix_data,
   input  logic             ppu_line_done,
   input  logic             vga_line_start,
   input  logic [IDX_W-1:0] vga_buf_idx,
   output logic [PIX_W-1:0] vga_buf_out,
   output logic             wr_stall,
   output logic             rd_valid
`ifdef VGA_LINEBUF_STATS_EN
   ,
   output logic [15:0]      overrun_cnt,
   output logic [15:0]      underrun_cnt
`endif
);

   localparam logic [1:0] REP_LAST = 2'(REPEAT - 1);

   vga_lb_wr_state_t wr_state_q, wr_state_d;
   vga_lb_rd_state_t rd_state_q, rd_state_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       full_q, full_d;
   logic [1:0]       rep_cnt_q, rep_cnt_d;

   logic             line_start, done_set, rep_last, other_rd_full, release_rd;
   logic [1:0]       set_mask, clr_mask, full_avail;
   logic             pix_in_range, rd_in_range;
   logic [1:0]       bank_we;
   logic [PIX_W-1:0] bank_rdata [2];

   if (2**IDX_W > LINE_W) begin : g_range
      assign pix_in_range = 32'(ppu_pix_x) < LINE_W;
      assign rd_in_range  = 32'(vga_buf_idx) < LINE_W;
   end else begin : g_norange
      assign pix_in_range = 1'b1;
      assign rd_in_range  = 1'b1;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      vga_linebuf_bank #(
         .LINE_W (LINE_W),
         .IDX_W  (IDX_W),
         .PIX_W  (PIX_W)
      ) u_bank (
         .clk     (clk),
         .wr_en   (bank_we[b]),
         .wr_idx  (ppu_pix_x),
         .wr_data (ppu_pix_data),
         .rd_idx  (vga_buf_idx),
         .rd_data (bank_rdata[b])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WR_FILL;
         rd_state_q <= RD_IDLE;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b1;
         full_q     <= 2'b00;
         rep_cnt_q  <= 2'd0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         rep_cnt_q  <= rep_cnt_d;
      end
   end

   // A line completed this cycle is visible to the reader immediately, and the
   // reader's release is visible to the writer, so a simultaneous done+release
   // swaps both sides without passing through WR_STALL.
   always_comb begin
      line_start    = clk_en && vga_line_start;
      done_set      = clk_en && ppu_line_done && (wr_state_q == WR_FILL);
      set_mask      = done_set ? (2'b01 << wr_bank_q) : 2'b00;
      full_avail    = full_q | set_mask;
      other_rd_full = full_avail[~rd_bank_q];
      rep_last      = (rep_cnt_q == REP_LAST);
      release_rd    = line_start && (rd_state_q == RD_SHOW) && rep_last && other_rd_full;
      clr_mask      = release_rd ? (2'b01 << rd_bank_q) : 2'b00;
      full_d        = full_avail & ~clr_mask;

      wr_state_d = wr_state_q;
      wr_bank_d  = wr_bank_q;
      case (wr_state_q)
         WR_FILL: begin
            if (done_set) begin
               if (!full_d[~wr_bank_q]) wr_bank_d  = ~wr_bank_q;
               else                     wr_state_d = WR_STALL;
            end
         end
         WR_STALL: begin
            if (clk_en && !full_d[~wr_bank_q]) begin
               wr_bank_d  = ~wr_bank_q;
               wr_state_d = WR_FILL;
            end
         end
         default: wr_state_d = WR_FILL;
      endcase

      rd_state_d = rd_state_q;
      rd_bank_d  = rd_bank_q;
      rep_cnt_d  = rep_cnt_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (line_start && other_rd_full) begin
               rd_bank_d  = ~rd_bank_q;
               rep_cnt_d  = 2'd0;
               rd_state_d = RD_SHOW;
            end
         end
         RD_SHOW: begin
            if (line_start) begin
               if (!rep_last) begin
                  rep_cnt_d = rep_cnt_q + 2'd1;
               end else if (other_rd_full) begin
                  rd_bank_d = ~rd_bank_q;
                  rep_cnt_d = 2'd0;
               end
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_stall = (wr_state_q == WR_STALL);
      rd_valid = (rd_state_q == RD_SHOW);
      bank_we  = 2'b00;
      if (clk_en && ppu_pix_we && (wr_state_q == WR_FILL) && pix_in_range) begin
         bank_we[wr_bank_q] = 1'b1;
      end
      vga_buf_out = UNDERRUN_PIX;
      if (rd_valid && rd_in_range) vga_buf_out = bank_rdata[rd_bank_q];
   end

`ifdef VGA_LINEBUF_STATS_EN
   logic        ever_done_q, ever_done_d;
   logic        overrun_evt, underrun_evt;
   logic [15:0] overrun_cnt_q, overrun_cnt_d;
   logic [15:0] underrun_cnt_q, underrun_cnt_d;

   // Idle line starts only count as underruns once a line has ever been delivered.
   always_comb begin
      overrun_evt  = clk_en && ppu_line_done && (wr_state_q == WR_STALL);
      underrun_evt = line_start && !other_rd_full &&
                     (((rd_state_q == RD_SHOW) && rep_last) ||
                      ((rd_state_q == RD_IDLE) && ever_done_q));
      ever_done_d    = ever_done_q | done_set;
      overrun_cnt_d  = overrun_cnt_q;
      underrun_cnt_d = underrun_cnt_q;
      if (overrun_evt && (overrun_cnt_q != 16'hFFFF))   overrun_cnt_d  = overrun_cnt_q + 16'd1;
      if (underrun_evt && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ever_done_q    <= 1'b0;
         overrun_cnt_q  <= 16'd0;
         underrun_cnt_q <= 16'd0;
      end else begin
         ever_done_q    <= ever_done_d;
         overrun_cnt_q  <= overrun_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign overrun_cnt  = overrun_cnt_q;
   assign underrun_cnt = underrun_cnt_q;
`endif

`ifndef SYNTHESIS
   bank_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
      ((wr_state_q == WR_FILL) && (rd_state_q == RD_SHOW)) |-> (wr_bank_q != rd_bank_q));
`endif

endmodule

// File: tb/tb_vga_linebuf_ctrl.sv
// Scoreboard bench for vga_linebuf_ctrl; counter checks apply when VGA_LINEBUF_STATS_EN is defined.
module tb_vga_linebuf_ctrl;

   typedef struct packed {
      logic [95:0] tag;
      logic        ev;
      logic        es;
      logic [5:0]  ep;
      logic [15:0] eo;
      logic [15:0] eu;
      logic        cs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_en = 1'b1;
   logic       ppu_pix_we = 1'b0;
   logic [7:0] ppu_pix_x = 8'd0;
   logic [5:0] ppu_pix_data = 6'd0;
   logic       ppu_line_done = 1'b0;
   logic       vga_line_start = 1'b0;
   logic [7:0] vga_buf_idx = 8'd0;
   logic [5:0] vga_buf_out;
   logic       wr_stall;
   logic       rd_valid;
`ifdef VGA_LINEBUF_STATS_EN
   logic [15:0] overrun_cnt;
   logic [15:0] underrun_cnt;
`endif

   exp_t exp_q[$];
   logic probe = 1'b0;
   logic drain = 1'b0;
   logic slow_mode = 1'b0;
   int   checks = 0;
   int   failures = 0;

   vga_linebuf_ctrl u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clk_en         (clk_en),
      .ppu_pix_we     (ppu_pix_we),
      .ppu_pix_x      (ppu_pix_x),
      .ppu_pix_data   (ppu_pix_data),
      .ppu_line_done  (ppu_line_done),
      .vga_line_start (vga_line_start),
      .vga_buf_idx    (vga_buf_idx),
      .vga_buf_out    (vga_buf_out),
      .wr_stall       (wr_stall),
      .rd_valid       (rd_valid)
`ifdef VGA_LINEBUF_STATS_EN
      ,
      .overrun_cnt    (overrun_cnt),
      .underrun_cnt   (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Watchdog so a broken run still terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic bit is_bad(input exp_t e);
      bit bad;
      bad = (rd_valid !== e.ev) || (wr_stall !== e.es) || (vga_buf_out !== e.ep);
`ifdef VGA_LINEBUF_STATS_EN
      if (e.cs && ((overrun_cnt !== e.eo) || (underrun_cnt !== e.eu))) bad = 1'b1;
`endif
      return bad;
   endfunction

   // Monitor: pops one expectation whenever the bench raises a probe.
   always @(negedge clk) begin
      if (probe) begin
         checks <= checks + 1;
         if (exp_q.size() == 0) begin
            failures <= failures + 1;
            $display("[TB] FAIL no_expectation: got valid=%b stall=%b pix=%h", rd_valid, wr_stall, vga_buf_out);
         end else begin
            if (is_bad(exp_q[0])) begin
               failures <= failures + 1;
`ifdef VGA_LINEBUF_STATS_EN
               $display("[TB] FAIL %0s: got valid=%b stall=%b pix=%h ovr=%0d und=%0d, expected valid=%b stall=%b pix=%h ovr=%0d und=%0d",
                        exp_q[0].tag, rd_valid, wr_stall, vga_buf_out, overrun_cnt, underrun_cnt,
                        exp_q[0].ev, exp_q[0].es, exp_q[0].ep, exp_q[0].eo, exp_q[0].eu);
`else
               $display("[TB] FAIL %0s: got valid=%b stall=%b pix=%h, expected valid=%b stall=%b pix=%h",
                        exp_q[0].tag, rd_valid, wr_stall, vga_buf_out,
                        exp_q[0].ev, exp_q[0].es, exp_q[0].ep);
`endif
            end
            exp_q.delete(0);
         end
      end else if (drain) begin
         checks <= checks + 1;
         if (exp_q.size() != 0) begin
            failures <= failures + 1;
            $display("[TB] FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One input vector; in slow mode it is held for an enabled and a disabled cycle.
   task automatic applyStimulus(input logic we, input logic [7:0] x, input logic [5:0] d,
                                input logic done, input logic start);
      ppu_pix_we     = we;
      ppu_pix_x      = x;
      ppu_pix_data   = d;
      ppu_line_done  = done;
      vga_line_start = start;
      clk_en = 1'b1;
      tick();
      if (slow_mode) begin
         clk_en = 1'b0;
         tick();
      end
      ppu_pix_we     = 1'b0;
      ppu_line_done  = 1'b0;
      vga_line_start = 1'b0;
   endtask

   task automatic checkOutput(input logic [95:0] tag, input logic [7:0] idx, input logic ev,
                              input logic es, input logic [5:0] ep, input logic [15:0] eo,
                              input logic [15:0] eu, input logic cs);
      exp_t e;
      vga_buf_idx = idx;
      e.tag = tag; e.ev = ev; e.es = es; e.ep = ep; e.eo = eo; e.eu = eu; e.cs = cs;
      exp_q.push_back(e);
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   function automatic logic [5:0] pix_of(input int pat, input int x);
      logic [5:0] v;
      v = 6'(x);
      case (pat)
         0:       return v;
         1:       return ~v;
         default: return 6'h2A;
      endcase
   endfunction

   task automatic write_line(input int pat, input int n);
      for (int x = 0; x < n; x++) applyStimulus(1'b1, 8'(x), pix_of(pat, x), 1'b0, 1'b0);
   endtask

   task automatic line_done();
      applyStimulus(1'b0, 8'd0, 6'd0, 1'b1, 1'b0);
   endtask

   task automatic line_start();
      applyStimulus(1'b0, 8'd0, 6'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // Reset state and idle reads.
      do_reset();
      checkOutput("t1_rst",    8'd0,   1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t1_idx0",   8'd0,   1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      checkOutput("t1_idx37",  8'd37,  1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      checkOutput("t1_idx255", 8'd255, 1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);

      // First line, line doubling and a release into a second line.
      write_line(0, 256);
      line_done();
      checkOutput("t2_pre",    8'd37,  1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t2_r1_37",  8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd0, 1'b1);
      checkOutput("t2_r1_0",   8'd0,   1'b1, 1'b0, 6'h00, 16'd0, 16'd0, 1'b1);
      checkOutput("t2_r1_255", 8'd255, 1'b1, 1'b0, 6'h3F, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t2_r2_37",  8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd0, 1'b1);
      write_line(1, 256);
      line_done();
      checkOutput("t2_stall",  8'd37,  1'b1, 1'b1, 6'h25, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t2_swap37", 8'd37,  1'b1, 1'b0, 6'h1A, 16'd0, 16'd0, 1'b1);
      checkOutput("t2_swap5",  8'd5,   1'b1, 1'b0, 6'h3A, 16'd0, 16'd0, 1'b1);

      // Overrun: third line is dropped while both banks are full.
      do_reset();
      write_line(0, 256);
      line_done();
      write_line(1, 256);
      line_done();
      checkOutput("t3_stall",  8'd37,  1'b0, 1'b1, 6'h0F, 16'd0, 16'd0, 1'b1);
      write_line(2, 256);
      line_done();
      checkOutput("t3_ovr",    8'd37,  1'b0, 1'b1, 6'h0F, 16'd1, 16'd0, 1'b1);
      line_start();
      checkOutput("t3_showA",  8'd37,  1'b1, 1'b1, 6'h25, 16'd1, 16'd0, 1'b1);
      line_start();
      line_start();
      checkOutput("t3_rel",    8'd37,  1'b1, 1'b0, 6'h1A, 16'd1, 16'd0, 1'b1);
      checkOutput("t3_drop",   8'd5,   1'b1, 1'b0, 6'h3A, 16'd1, 16'd0, 1'b1);

      // Underrun: one line repeated past REPEAT rows without being released.
      do_reset();
      write_line(0, 256);
      line_done();
      line_start();
      checkOutput("t4_r1",     8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd0, 1'b1);
      line_start();
      line_start();
      checkOutput("t4_r3",     8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd1, 1'b1);
      line_start();
      checkOutput("t4_r4",     8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd2, 1'b1);
      write_line(1, 256);
      line_done();
      checkOutput("t4_keep",   8'd37,  1'b1, 1'b1, 6'h25, 16'd0, 16'd2, 1'b1);
      line_start();
      checkOutput("t4_rel",    8'd37,  1'b1, 1'b0, 6'h1A, 16'd0, 16'd2, 1'b1);

      // Line done coinciding with the releasing line start.
      do_reset();
      write_line(0, 256);
      line_done();
      line_start();
      line_start();
      write_line(1, 256);
      applyStimulus(1'b0, 8'd0, 6'd0, 1'b1, 1'b1);
      checkOutput("t5_same",   8'd37,  1'b1, 1'b0, 6'h1A, 16'd0, 16'd0, 1'b1);
      write_line(2, 256);
      line_done();
      checkOutput("t5_stall",  8'd37,  1'b1, 1'b1, 6'h1A, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t5_rep",    8'd37,  1'b1, 1'b1, 6'h1A, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t5_next",   8'd37,  1'b1, 1'b0, 6'h2A, 16'd0, 16'd0, 1'b1);

      // Half-rate enable with an asynchronous reset in the middle of a line.
      do_reset();
      slow_mode = 1'b1;
      write_line(0, 256);
      line_done();
      checkOutput("t6_nostall", 8'd37, 1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      line_start();
      checkOutput("t6_show",   8'd37,  1'b1, 1'b0, 6'h25, 16'd0, 16'd0, 1'b1);
      write_line(1, 100);
      #1;
      rst_n = 1'b0;
      checkOutput("t6_async",  8'd37,  1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      rst_n = 1'b1;
      tick();
      line_start();
      checkOutput("t6_disc",   8'd37,  1'b0, 1'b0, 6'h0F, 16'd0, 16'd0, 1'b1);
      write_line(1, 256);
      line_done();
      line_start();
      checkOutput("t6_post",   8'd37,  1'b1, 1'b0, 6'h1A, 16'd0, 16'd0, 1'b1);
      slow_mode = 1'b0;
      clk_en = 1'b1;

      drain = 1'b1;
      tick();
      drain = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_linebuf_ctrl.md
Name: vga_linebuf_ctrl

Overview:
- Ping-pong scanline buffer controller between the PPU pixel pipeline (writer) and the VGA scan-out (reader).
- The PPU writes one 256-pixel line of 6-bit palette indices into the write bank. The VGA reads the other bank, showing each buffered line on REPEAT consecutive VGA rows (line doubling).
- Swaps banks at line boundaries, arbitrates bank ownership, and handles overrun and underrun deterministically.

Parameters:
- LINE_W, 256, pixels per line; bank depth.
- IDX_W, 8, index width; must satisfy 2**IDX_W >= LINE_W.
- PIX_W, 6, palette index width.
- REPEAT, 2, VGA rows per buffered line, 1..4.
- UNDERRUN_PIX, 6'h0F, pixel returned before any line has been completed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- clk_en  in  1  pixel-rate enable; all state updates occur only when high.
- ppu_pix_we  in  1  pixel write strobe.
- ppu_pix_x  in  IDX_W  pixel column.
- ppu_pix_data  in  PIX_W  palette index.
- ppu_line_done  in  1  single-cycle pulse: current write line complete.
- vga_line_start  in  1  single-cycle pulse at VGA col 0 of a visible row.
- vga_buf_idx  in  IDX_W  read column.
- vga_buf_out  out  PIX_W  read pixel (combinational from bank, see Behaviour).
- wr_stall  out  1  both banks full; PPU writes are dropped.
- rd_valid  out  1  read bank holds a completed line.

Behaviour:
- Reset: wr_bank=0, rd_bank=1, full[1:0]=0, rep_cnt=0, wr_state=WR_FILL, rd_state=RD_IDLE. Outputs: wr_stall=0, rd_valid=0, vga_buf_out=UNDERRUN_PIX. Bank contents are not reset.
- Writes:
  - In WR_FILL with clk_en & ppu_pix_we & ppu_pix_x<LINE_W: mem[wr_bank][ppu_pix_x] <= ppu_pix_data.
  - x >= LINE_W is ignored.
  - Writes in WR_STALL are dropped.
- Write-side FSM:
  - WR_FILL --ppu_line_done--> set full[wr_bank]. If other bank is not full (evaluated after the same-cycle read release), toggle wr_bank and stay in WR_FILL; else go to WR_STALL.
  - WR_STALL --other bank released--> toggle wr_bank, go to WR_FILL.
  - ppu_line_done in WR_STALL is ignored (line lost; counted as overrun).
- Read-side FSM:
  - RD_IDLE --vga_line_start & full[~rd_bank]--> rd_bank<=~rd_bank, rep_cnt<=0, go to RD_SHOW.
  - RD_SHOW on vga_line_start:
    - If rep_cnt<REPEAT-1: rep_cnt++.
    - Else if full[~rd_bank]: clear full[rd_bank] (release), rd_bank<=~rd_bank, rep_cnt<=0.
    - Else (underrun): keep rd_bank, hold rep_cnt at REPEAT-1, re-show the same line, do not release.
- vga_buf_out:
  - RD_SHOW: mem[rd_bank][vga_buf_idx], zero read latency.
  - RD_IDLE: UNDERRUN_PIX.
  - vga_buf_idx >= LINE_W also returns UNDERRUN_PIX.
- Bank select changes take effect on the clock edge of the accepting vga_line_start. The first pixel of the new row reads the new bank.
- Simultaneous ppu_line_done and release in one cycle:
  - Release is applied first.
  - A writer that would otherwise stall instead toggles into the freed bank.
  - The writer never targets rd_bank while in WR_FILL.
- Invariant: wr_bank != rd_bank whenever wr_state=WR_FILL and rd_state=RD_SHOW. Assert in RTL under synthesis-off.
- rd_valid = (rd_state==RD_SHOW). wr_stall = (wr_state==WR_STALL).
- rst_n asserted mid-line: immediate return to reset state. The partial line is discarded (full flags cleared).

Optional Feature:
- Macro: VGA_LINEBUF_STATS_EN.
- Defined: adds outputs overrun_cnt[15:0] and underrun_cnt[15:0].
  - Both are saturating counters (stop at 16'hFFFF), reset to 0.
  - overrun_cnt increments on ppu_line_done in WR_STALL.
  - underrun_cnt increments on each RD_SHOW underrun repeat, and on vga_line_start in RD_IDLE after the first line has ever completed.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- ppu_defines package:
  - vga_lb_wr_state_t {WR_FILL, WR_STALL}.
  - vga_lb_rd_state_t {RD_IDLE, RD_SHOW}.
  - Constants LB_LINE_W=256 and LB_UNDERRUN_PIX=6'h0F.
- Sub-module vga_linebuf_bank: LINE_W x PIX_W register array, one sync write port, one async read port; instantiated twice. Controller FSMs and bank muxing stay in vga_linebuf_ctrl.

Test Plan:
1. Reset, then vga_line_start with no PPU activity -> rd_valid=0, vga_buf_out=6'h0F for every idx; wr_stall=0.
2. Write pixel value x&6'h3F for x=0..255, pulse ppu_line_done, then vga_line_start -> rd_valid=1; vga_buf_out at idx 37 = 6'h25; same line shown for 2 rows; released at the 3rd vga_line_start only if a second line is full.
3. Complete 3 lines with no vga_line_start -> wr_stall=1 after line 2; line-3 writes dropped; overrun_cnt=1 (STATS_EN). After the next release, wr_stall=0 within 1 enabled cycle.
4. Complete one line, then issue 4 vga_line_start -> rows 3–4 repeat the same data (underrun); underrun_cnt=2 (STATS_EN); full flag of the displayed bank is not cleared.
5. ppu_line_done and releasing vga_line_start in the same cycle with both banks full -> no stall; writer moves to the freed bank; next line data appears after the following swap.
6. rst_n pulsed mid-line with clk_en toggling 1-of-2 -> all outputs return to reset values asynchronously; the first post-reset line displays correctly.
